// File: rtl/clip_player.sv
// Sample-paced clip player: fetches 6-bit samples from an audio ROM and pushes them to the
// audio controller at one sample per CLKS_PER_SAMPLE clocks. Define CLIP_PLAYER_LOOP_EN to honour loop.
module clip_player #(
  parameter int unsigned CLKS_PER_SAMPLE = 1200,
  parameter int unsigned ROM_LAT         = 2
) (
  input  logic        CLOCK_50,
  input  logic        resetn,
  input  logic        start,
  input  logic [1:0]  clip_sel,
  input  logic        stop,
  input  logic        loop,
  input  logic [5:0]  rom_q,
  input  logic        audio_out_allowed,
  output logic [17:0] rom_addr,
  output logic [31:0] sample_out,
  output logic        write_audio_out,
  output logic        busy,
  output logic        done,
  output logic        underrun
);

  localparam logic [17:0] WinStart    = 18'd0;
  localparam logic [17:0] WinEnd      = 18'd16395;
  localparam logic [17:0] MooStart    = 18'd16396;
  localparam logic [17:0] MooEnd      = 18'd66982;
  localparam logic [17:0] DetectStart = 18'd66983;
  localparam logic [17:0] DetectEnd   = 18'd83254;
  localparam logic [17:0] CheerStart  = 18'd83255;
  localparam logic [17:0] CheerEnd    = 18'd137138;

  localparam int unsigned CntW = (CLKS_PER_SAMPLE > 1) ? $clog2(CLKS_PER_SAMPLE) : 1;
  localparam int unsigned LatW = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_SAMPLE - 1);
  localparam logic [LatW-1:0] LatMax = LatW'(ROM_LAT - 1);

  typedef enum logic [2:0] {StIdle, StFetch, StWaitSlot, StPush, StPace} state_e;

  state_e          state;
  logic [1:0]      clip;
  logic [CntW-1:0] tick_cnt;
  logic [LatW-1:0] lat_cnt;
  logic [5:0]      sample_q;
  logic            tick;
  logic            at_end;
  logic            loop_en;
  logic [17:0]     cur_start;
  logic [17:0]     cur_end;

  function automatic logic [17:0] clip_start(input logic [1:0] sel);
    unique case (sel)
      2'd0:    return WinStart;
      2'd1:    return MooStart;
      2'd2:    return DetectStart;
      default: return CheerStart;
    endcase
  endfunction

  function automatic logic [17:0] clip_end(input logic [1:0] sel);
    unique case (sel)
      2'd0:    return WinEnd;
      2'd1:    return MooEnd;
      2'd2:    return DetectEnd;
      default: return CheerEnd;
    endcase
  endfunction

`ifdef CLIP_PLAYER_LOOP_EN
  assign loop_en = loop;
`else
  logic unused_loop;
  assign unused_loop = loop;
  assign loop_en     = 1'b0;
`endif

  assign cur_start  = clip_start(clip);
  assign cur_end    = clip_end(clip);
  assign at_end     = (rom_addr >= cur_end);
  assign tick       = (state != StIdle) && (tick_cnt == CntMax);
  assign sample_out = {sample_q, 26'b0};

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state           <= StIdle;
      clip            <= 2'd0;
      tick_cnt        <= '0;
      lat_cnt         <= '0;
      sample_q        <= 6'd0;
      rom_addr        <= 18'd0;
      write_audio_out <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      underrun        <= 1'b0;
    end else begin
      done            <= 1'b0;
      underrun        <= 1'b0;
      write_audio_out <= 1'b0;
      if (state != StIdle) tick_cnt <= tick ? '0 : tick_cnt + 1'b1;

      if (stop) begin
        state    <= StIdle;
        busy     <= 1'b0;
        tick_cnt <= '0;
      end else if (start) begin
        clip     <= clip_sel;
        rom_addr <= clip_start(clip_sel);
        tick_cnt <= '0;
        lat_cnt  <= '0;
        state    <= StFetch;
        busy     <= 1'b1;
      end else if (tick) begin
        // The sample period is fixed by the tick; an unfinished fetch/handshake is dropped.
        if (state == StFetch || state == StWaitSlot) underrun <= 1'b1;
        if (!at_end) begin
          rom_addr <= rom_addr + 18'd1;
          lat_cnt  <= '0;
          state    <= StFetch;
        end else if (loop_en) begin
          rom_addr <= cur_start;
          lat_cnt  <= '0;
          state    <= StFetch;
        end else begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= StIdle;
        end
      end else begin
        case (state)
          StFetch: begin
            if (lat_cnt == LatMax) begin
              sample_q <= rom_q;
              state    <= StWaitSlot;
            end else begin
              lat_cnt <= lat_cnt + 1'b1;
            end
          end
          StWaitSlot: begin
            if (audio_out_allowed) begin
              write_audio_out <= 1'b1;
              state           <= StPush;
            end
          end
          StPush:  state <= StPace;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clip_player.sv
// Directed bench for clip_player: a CLKS_PER_SAMPLE=4 instance for the main scenarios and a
// CLKS_PER_SAMPLE=1 instance to reach the end of clip 0 quickly for the loop check.
module tb_clip_player;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, start, stop, loop1, allowed;
  logic [1:0]  clip_sel;
  logic [5:0]  rom_q, rom_key;
  logic [17:0] rom_addr;
  logic [31:0] sample_out;
  logic        wr, busy, done, underrun;

  logic        start2, stop2, loop2, allowed2;
  logic [1:0]  clip_sel2;
  logic [5:0]  rom_q2;
  logic [17:0] rom_addr2;
  logic [31:0] sample_out2;
  logic        wr2, busy2, done2, underrun2;

  int checks = 0;
  int passes = 0;

  // Synchronous ROM model: data follows the registered address by one further clock.
  always @(posedge clk) rom_q <= rom_addr[5:0] ^ rom_key;

  clip_player #(.CLKS_PER_SAMPLE(4), .ROM_LAT(2)) dut (
    .CLOCK_50(clk), .resetn(resetn), .start(start), .clip_sel(clip_sel), .stop(stop),
    .loop(loop1), .rom_q(rom_q), .audio_out_allowed(allowed), .rom_addr(rom_addr),
    .sample_out(sample_out), .write_audio_out(wr), .busy(busy), .done(done),
    .underrun(underrun)
  );

  clip_player #(.CLKS_PER_SAMPLE(1), .ROM_LAT(2)) dut2 (
    .CLOCK_50(clk), .resetn(resetn), .start(start2), .clip_sel(clip_sel2), .stop(stop2),
    .loop(loop2), .rom_q(rom_q2), .audio_out_allowed(allowed2), .rom_addr(rom_addr2),
    .sample_out(sample_out2), .write_audio_out(wr2), .busy(busy2), .done(done2),
    .underrun(underrun2)
  );

  task automatic test_reset();
    resetn = 1'b0; start = 1'b1; clip_sel = 2'd2;
    @(negedge clk); @(negedge clk);
    checks++; if (rom_addr !== 18'd0) $display("FAIL reset_rom_addr got %0d want 0", rom_addr); else passes++;
    checks++; if (sample_out !== 32'd0) $display("FAIL reset_sample got %h want 0", sample_out); else passes++;
    checks++; if (wr !== 1'b0) $display("FAIL reset_write got %b want 0", wr); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passes++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passes++;
    checks++; if (underrun !== 1'b0) $display("FAIL reset_underrun got %b want 0", underrun); else passes++;
    checks++; if (busy2 !== 1'b0) $display("FAIL reset_busy2 got %b want 0", busy2); else passes++;
    start = 1'b0; resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_clip();
    int nwr = 0, ndone = 0, nund = 0, cyc = 0, last_wr = 0, first_wr = -1;
    int bad_gap = 0, bad_addr = 0, bad_data = 0;
    logic [31:0] first_sample = 32'd0;
    logic [17:0] last_addr = 18'd0;
    start = 1'b1; clip_sel = 2'd2; allowed = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (ndone == 0 && cyc < 70000) begin
      if (wr) begin
        if (nwr == 0) begin
          first_sample = sample_out;
          first_wr = cyc;
        end else if (cyc - last_wr != 4) begin
          bad_gap++;
        end
        if (rom_addr != 18'(66983 + nwr)) bad_addr++;
        if (sample_out != {rom_addr[5:0] ^ rom_key, 26'b0}) bad_data++;
        last_wr = cyc;
        last_addr = rom_addr;
        nwr++;
      end
      if (underrun) nund++;
      if (done) ndone++;
      if (ndone == 0) begin
        @(negedge clk);
        cyc++;
      end
    end
    checks++; if (busy !== 1'b0) $display("FAIL full_busy_end got %b want 0", busy); else passes++;
    checks++; if (cyc != 65088) $display("FAIL full_done_cycle got %0d want 65088", cyc); else passes++;
    repeat (4) begin
      @(negedge clk);
      if (done) ndone++;
    end
    checks++; if (first_sample !== 32'hA800_0000) $display("FAIL first_sample got %h want a8000000", first_sample); else passes++;
    checks++; if (first_wr != 3) $display("FAIL first_write_cycle got %0d want 3", first_wr); else passes++;
    checks++; if (nwr != 16272) $display("FAIL full_writes got %0d want 16272", nwr); else passes++;
    checks++; if (nund != 0) $display("FAIL full_underruns got %0d want 0", nund); else passes++;
    checks++; if (bad_gap != 0) $display("FAIL full_write_spacing got %0d bad want 0", bad_gap); else passes++;
    checks++; if (bad_addr != 0) $display("FAIL full_addr_walk got %0d bad want 0", bad_addr); else passes++;
    checks++; if (bad_data != 0) $display("FAIL full_sample_data got %0d bad want 0", bad_data); else passes++;
    checks++; if (last_addr !== 18'd83254) $display("FAIL full_last_addr got %0d want 83254", last_addr); else passes++;
    checks++; if (ndone != 1) $display("FAIL full_done_pulses got %0d want 1", ndone); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL full_busy_after got %b want 0", busy); else passes++;
  endtask

  task automatic test_underrun();
    int nund = 0, nwr = 0;
    logic [17:0] a0 = '0, a4 = '0, a9 = '0;
    logic und4 = 1'b0;
    logic [5:0] exp_q;
    start = 1'b1; clip_sel = 2'd1; allowed = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (underrun) nund++;
      if (wr) nwr++;
      if (i == 0) a0 = rom_addr;
      if (i == 4) begin a4 = rom_addr; und4 = underrun; end
      if (i == 9) a9 = rom_addr;
      if (i < 9) @(negedge clk);
    end
    allowed = 1'b1;
    @(negedge clk); @(negedge clk);
    exp_q = 6'd14 ^ rom_key;
    checks++; if (a0 !== 18'd16396) $display("FAIL und_addr_c0 got %0d want 16396", a0); else passes++;
    checks++; if (a4 !== 18'd16397) $display("FAIL und_addr_c4 got %0d want 16397", a4); else passes++;
    checks++; if (a9 !== 18'd16398) $display("FAIL und_addr_c9 got %0d want 16398", a9); else passes++;
    checks++; if (und4 !== 1'b1) $display("FAIL und_pulse_c4 got %b want 1", und4); else passes++;
    checks++; if (nund != 2) $display("FAIL und_count got %0d want 2", nund); else passes++;
    checks++; if (nwr != 0) $display("FAIL und_writes got %0d want 0", nwr); else passes++;
    checks++; if (wr !== 1'b1) $display("FAIL und_resume_write got %b want 1", wr); else passes++;
    checks++; if (sample_out !== {exp_q, 26'b0}) $display("FAIL und_resume_sample got %h want %h", sample_out, {exp_q, 26'b0}); else passes++;
  endtask

  task automatic test_restart();
    @(negedge clk);
    start = 1'b1; clip_sel = 2'd3;
    @(negedge clk);
    start = 1'b0;
    checks++; if (rom_addr !== 18'd83255) $display("FAIL restart_addr got %0d want 83255", rom_addr); else passes++;
    checks++; if (busy !== 1'b1) $display("FAIL restart_busy got %b want 1", busy); else passes++;
    checks++; if (done !== 1'b0) $display("FAIL restart_done got %b want 0", done); else passes++;
  endtask

  task automatic test_stop_wins();
    int nwr = 0, nbusy = 0;
    start = 1'b1; clip_sel = 2'd0; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    checks++; if (busy !== 1'b0) $display("FAIL stop_busy got %b want 0", busy); else passes++;
    checks++; if (rom_addr !== 18'd83255) $display("FAIL stop_addr_hold got %0d want 83255", rom_addr); else passes++;
    checks++; if (done !== 1'b0) $display("FAIL stop_done got %b want 0", done); else passes++;
    repeat (6) begin
      @(negedge clk);
      if (wr) nwr++;
      if (busy) nbusy++;
    end
    checks++; if (nwr + nbusy != 0) $display("FAIL stop_idle_activity got %0d want 0", nwr + nbusy); else passes++;
  endtask

  task automatic test_reset_mid();
    start = 1'b1; clip_sel = 2'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (sample_out !== 32'hA800_0000) $display("FAIL mid_sample_before got %h want a8000000", sample_out); else passes++;
    resetn = 1'b0; start = 1'b1; clip_sel = 2'd3;
    @(negedge clk);
    checks++; if (rom_addr !== 18'd0) $display("FAIL mid_rst_addr got %0d want 0", rom_addr); else passes++;
    checks++; if (sample_out !== 32'd0) $display("FAIL mid_rst_sample got %h want 0", sample_out); else passes++;
    checks++; if ({wr, busy, done, underrun} !== 4'b0) $display("FAIL mid_rst_flags got %b want 0000", {wr, busy, done, underrun}); else passes++;
    resetn = 1'b1; start = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) $display("FAIL mid_rst_start_ignored got %b want 0", busy); else passes++;
  endtask

  task automatic test_loop();
    int n = 0;
    start2 = 1'b1; clip_sel2 = 2'd0;
    @(negedge clk);
    start2 = 1'b0;
    checks++; if (rom_addr2 !== 18'd0 || busy2 !== 1'b1) $display("FAIL loop_start got addr %0d busy %b want 0/1", rom_addr2, busy2); else passes++;
    @(negedge clk);
    checks++; if (underrun2 !== 1'b1 || rom_addr2 !== 18'd1) $display("FAIL loop_fast_tick got und %b addr %0d want 1/1", underrun2, rom_addr2); else passes++;
    while (rom_addr2 != 18'd16395 && n < 17000) begin
      @(negedge clk);
      n++;
    end
    checks++; if (rom_addr2 !== 18'd16395) $display("FAIL loop_reach_end got %0d want 16395", rom_addr2); else passes++;
    @(negedge clk);
`ifdef CLIP_PLAYER_LOOP_EN
    checks++; if (rom_addr2 !== 18'd0) $display("FAIL loop_wrap_addr got %0d want 0", rom_addr2); else passes++;
    checks++; if (done2 !== 1'b0) $display("FAIL loop_no_done got %b want 0", done2); else passes++;
    checks++; if (busy2 !== 1'b1) $display("FAIL loop_busy got %b want 1", busy2); else passes++;
`else
    checks++; if (done2 !== 1'b1) $display("FAIL noloop_done got %b want 1", done2); else passes++;
    checks++; if (busy2 !== 1'b0) $display("FAIL noloop_idle got %b want 0", busy2); else passes++;
    checks++; if (rom_addr2 !== 18'd16395) $display("FAIL noloop_addr_hold got %0d want 16395", rom_addr2); else passes++;
`endif
    stop2 = 1'b1;
    @(negedge clk);
    stop2 = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; stop = 1'b0; loop1 = 1'b0; allowed = 1'b1; clip_sel = 2'd0;
    rom_key = 6'h0D;
    start2 = 1'b0; stop2 = 1'b0; loop2 = 1'b1; allowed2 = 1'b1; clip_sel2 = 2'd0; rom_q2 = 6'd0;
    test_reset();
    test_full_clip();
    test_underrun();
    test_restart();
    test_stop_wins();
    test_reset_mid();
    test_loop();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
